// File: rtl/prbs7_pkg.sv
// Shared PRBS7 definitions: polynomial step, sequence constants and the
// checker state encoding, used by both the generator and the checker.
package prbs7_pkg;

  localparam int PRBS_W = 7;
  localparam int PERIOD = 127;
  localparam logic [PRBS_W-1:0] RESET_SEED = 7'h7F;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } state_t;

  // x^7 + x^6 + 1: shift left, feed back the XOR of the two top bits
  function automatic logic [PRBS_W-1:0] prbs7_next(input logic [PRBS_W-1:0] w);
    return {w[5:0], w[6] ^ w[5]};
  endfunction

endpackage

// File: rtl/popcount7.sv
// Number of set bits in a 7-bit vector; used to weight bit errors.
module popcount7 (
  input  logic [6:0] vec,
  output logic [2:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 7; i++) begin
      count = count + {2'b00, vec[i]};
    end
  end

endmodule

// File: rtl/prbs7_checker.sv
// PRBS7 receive checker: hunts for the sequence, locks after a run of
// matching words, then flywheels its own prediction to count errors.
module prbs7_checker
  import prbs7_pkg::*;
#(
  parameter int LOCK_THRESH   = 4,
  parameter int UNLOCK_THRESH = 3,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [6:0]        in_data,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  word_err_cnt,
  output logic [CNT_W-1:0]  bit_err_cnt,
  output logic              zero_seen,
  output logic              wrap_pulse
);

  localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
  localparam int MISS_W  = $clog2(UNLOCK_THRESH + 1);

  state_t             state, state_nxt;
  logic [6:0]         prev, prev_nxt, pred;
  logic [MATCH_W-1:0] match_cnt, match_nxt;
  logic [MISS_W-1:0]  miss_cnt, miss_nxt;
  logic [6:0]         period_cnt, period_nxt;
  logic               err_nxt, wrap_nxt, zero_nxt;
  logic [CNT_W-1:0]   word_nxt, bit_nxt;
  logic [2:0]         bit_diff;
  logic [CNT_W:0]     bit_sum;

  assign pred = prbs7_next(prev);

  popcount7 u_popcount (
    .vec   (in_data ^ pred),
    .count (bit_diff)
  );

  // One extra bit catches overflow so the bit counter can clamp
  assign bit_sum = {1'b0, bit_err_cnt} + (CNT_W+1)'(bit_diff);

  always_comb begin
    state_nxt  = state;
    prev_nxt   = prev;
    match_nxt  = match_cnt;
    miss_nxt   = miss_cnt;
    period_nxt = period_cnt;
    err_nxt    = 1'b0;
    wrap_nxt   = 1'b0;
    zero_nxt   = zero_seen;
    word_nxt   = word_err_cnt;
    bit_nxt    = bit_err_cnt;

    if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_data == '0) begin
            zero_nxt = 1'b1;
          end else begin
            prev_nxt  = in_data;
            match_nxt = '0;
            state_nxt = SYNC;
          end
        end
        SYNC: begin
          prev_nxt = in_data;
          if (in_data == '0) begin
            zero_nxt  = 1'b1;
            match_nxt = '0;
            state_nxt = HUNT;
          end else if (in_data == pred) begin
            match_nxt = match_cnt + MATCH_W'(1);
            if (match_cnt == MATCH_W'(LOCK_THRESH - 1)) begin
              state_nxt  = LOCKED;
              miss_nxt   = '0;
              period_nxt = '0;
            end
          end else begin
            match_nxt = '0;
          end
        end
        LOCKED: begin
          // Flywheel: advance on our own prediction so a bad word does not
          // poison the next comparison
          prev_nxt   = pred;
          wrap_nxt   = (period_cnt == 7'(PERIOD - 1));
          period_nxt = wrap_nxt ? '0 : period_cnt + 7'd1;
          if (in_data == '0) zero_nxt = 1'b1;
          if (in_data == pred) begin
            miss_nxt = '0;
          end else begin
            err_nxt  = 1'b1;
            word_nxt = (&word_err_cnt) ? word_err_cnt : word_err_cnt + CNT_W'(1);
            bit_nxt  = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
            miss_nxt = miss_cnt + MISS_W'(1);
            if (miss_cnt == MISS_W'(UNLOCK_THRESH - 1)) begin
              miss_nxt  = '0;
              state_nxt = HUNT;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end

    if (clear) begin
      word_nxt = '0;
      bit_nxt  = '0;
      zero_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= HUNT;
      prev         <= '0;
      match_cnt    <= '0;
      miss_cnt     <= '0;
      period_cnt   <= '0;
      locked       <= 1'b0;
      err_pulse    <= 1'b0;
      wrap_pulse   <= 1'b0;
      zero_seen    <= 1'b0;
      word_err_cnt <= '0;
      bit_err_cnt  <= '0;
    end else begin
      state        <= state_nxt;
      prev         <= prev_nxt;
      match_cnt    <= match_nxt;
      miss_cnt     <= miss_nxt;
      period_cnt   <= period_nxt;
      locked       <= (state_nxt == LOCKED);
      err_pulse    <= err_nxt;
      wrap_pulse   <= wrap_nxt;
      zero_seen    <= zero_nxt;
      word_err_cnt <= word_nxt;
      bit_err_cnt  <= bit_nxt;
    end
  end

endmodule

// File: doc/prbs7_checker.md
PRBS7_CHECKER -- requirements
Module: prbs7_checker

Interface
REQ-001 The block SHALL have parameter LOCK_THRESH, default 4, meaning the number of consecutive matching valid words needed to declare lock.
REQ-002 The block SHALL have parameter UNLOCK_THRESH, default 3, meaning the number of consecutive mismatching valid words in LOCKED that drops lock.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the error counters.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 clear  input  1  synchronous clear of counters and sticky flag.
REQ-007 in_valid  input  1  in_data carries a new PRBS7 word this cycle (driven from the upstream LFSR enable).
REQ-008 in_data  input  7  received word (upstream lfsr_out).
REQ-009 locked  output  1  checker is synchronised to the stream.
REQ-010 err_pulse  output  1  one-cycle pulse per mismatching word while locked.
REQ-011 word_err_cnt  output  CNT_W  saturating count of mismatching words.
REQ-012 bit_err_cnt  output  CNT_W  saturating count of mismatching bits.
REQ-013 zero_seen  output  1  sticky flag: an illegal all-zero word was received.
REQ-014 wrap_pulse  output  1  one-cycle pulse per 127 consecutive locked valid words.

Function
REQ-015 Prediction SHALL be pred = {prev[5:0], prev[6]^prev[5]}, where prev is the last reference word.
REQ-016 FSM states SHALL be HUNT, SYNC, LOCKED; when in_valid=0, all state, registers and counters SHALL hold.
REQ-017 HUNT: a valid non-zero word SHALL load prev and set match_cnt=0 -> SYNC; a valid zero word SHALL set zero_seen and stay in HUNT.
REQ-018 SYNC: if in_data==pred, match_cnt++ and reaching LOCK_THRESH -> LOCKED; a mismatch SHALL set match_cnt=0 and stay in SYNC; prev<=in_data in both cases; a zero word SHALL return the FSM to HUNT.
REQ-019 LOCKED: prev<=pred (flywheel), so one corrupted word yields exactly one error.
REQ-020 LOCKED match SHALL clear miss_cnt.
REQ-021 LOCKED mismatch SHALL increment word_err_cnt by 1, increment bit_err_cnt by popcount(in_data^pred), pulse err_pulse and increment miss_cnt.
REQ-022 When miss_cnt reaches UNLOCK_THRESH, the FSM SHALL go to HUNT.
REQ-023 All outputs SHALL be registered; locked SHALL rise in the cycle after the LOCK_THRESH-th match is sampled; err_pulse SHALL assert in the cycle after the bad word.
REQ-024 locked SHALL deassert in the cycle after the UNLOCK_THRESH-th mismatch.
REQ-025 Both counters SHALL saturate at all-ones; a bit add that would overflow SHALL clamp to all-ones.
REQ-026 A period counter (0..126) SHALL count valid words in LOCKED and reset on lock entry; wrap_pulse SHALL assert when it wraps 126->0.
REQ-027 clear SHALL zero both counters and zero_seen without changing FSM state; clear coinciding with an error SHALL leave the counters at 0 (clear wins).
REQ-028 A zero word in LOCKED SHALL set zero_seen and be treated as an ordinary mismatch.

Reset
REQ-029 Reset SHALL force: state=HUNT; prev, match_cnt, miss_cnt and period counter to 0; all outputs to 0.
REQ-030 Reset SHALL take effect immediately, including mid-lock, and SHALL override clear and in_valid.

Structure
REQ-031 Package prbs7_pkg SHALL hold: the state enum, PRBS_W=7, PERIOD=127, RESET_SEED=7'h7F and the next-word function, shared with the generator.
REQ-032 One combinational sub-module popcount7 SHALL compute the number of set bits (0..7) of a 7-bit vector.

Verification
REQ-033 Locking: after reset, feed valid 7F,7E,7C,78,70 -> locked=1 the cycle after 70; counters remain 0.
REQ-034 Single error: while locked after 70, feed 61 (expected 60), then 40 -> err_pulse for one cycle; word_err_cnt=1; bit_err_cnt=1; 40 accepted; locked stays 1.
REQ-035 Loss of lock: while locked, feed three consecutive wrong words -> locked=0 after the third; FSM in HUNT; word_err_cnt=3.
REQ-036 Illegal zero: in HUNT, feed 00 -> zero_seen=1, locked stays 0; then assert clear -> zero_seen=0.
REQ-037 Long run: 300 clean locked words -> wrap_pulse after locked words 127 and 254; no err_pulse.
REQ-038 Corner cases: with CNT_W=4, inject 20 single-bit errors -> counters hold at 15. Assert reset mid-lock -> all outputs 0 immediately.
